// File: rtl/frame_mem_arbiter.sv
// ============================================================================
// frame_mem_arbiter: shares one frame memory port between video reads, audio
// reads and SPI writes, with SPI starvation promotion and SPI write bursts.
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_mem_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 8,
    parameter int SPI_STARVE = 8,
    parameter int SPI_BURST  = 4
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              aud_req,
    input  logic [ADDR_W-1:0] aud_addr,
    output logic              aud_gnt,
    output logic              aud_rvalid,
    output logic [DATA_W-1:0] aud_rdata,
    input  logic              spi_req,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW       = (SPI_STARVE < 1) ? 1 : $clog2(SPI_STARVE + 1);
    localparam int BW       = (SPI_BURST < 1) ? 1 : $clog2(SPI_BURST + 1);
    localparam bit BURST_EN = (SPI_BURST > 1);

    typedef enum logic [0:0] {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [SW-1:0]     starve_cnt, starve_nxt;
    logic [BW-1:0]     burst_cnt, burst_nxt;
    logic              promoted;
    logic              xfer;
    logic [ADDR_W-1:0] issue_addr;
    logic [1:0]        tag_s1, tag_s2;   // {video, audio} read owner per stage

    assign promoted = (starve_cnt >= SW'(SPI_STARVE));
    assign xfer     = vid_gnt | aud_gnt | spi_gnt;

    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state      <= ARB;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            tag_s1     <= '0;
            tag_s2     <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
            mem_en     <= xfer;
            mem_we     <= spi_gnt;
            if (xfer)
                mem_addr <= issue_addr;
            if (spi_gnt)
                mem_wdata <= spi_wdata;
            tag_s1     <= {vid_gnt, aud_gnt};
            tag_s2     <= tag_s1;
        end
    end

    always_comb begin
        vid_gnt    = 1'b0;
        aud_gnt    = 1'b0;
        spi_gnt    = 1'b0;
        state_nxt  = state;
        burst_nxt  = burst_cnt;
        starve_nxt = starve_cnt;
        issue_addr = spi_addr;

        // Video always wins; in BURST or once starved, SPI outranks audio.
        if (!reset) begin
            if (vid_req)
                vid_gnt = 1'b1;
            else if (state == BURST) begin
                if (spi_req)
                    spi_gnt = 1'b1;
                else if (aud_req)
                    aud_gnt = 1'b1;
            end else if (spi_req && promoted)
                spi_gnt = 1'b1;
            else if (aud_req)
                aud_gnt = 1'b1;
            else if (spi_req)
                spi_gnt = 1'b1;
        end

        if (vid_gnt)
            issue_addr = vid_addr;
        else if (aud_gnt)
            issue_addr = aud_addr;

        if (!spi_req || spi_gnt)
            starve_nxt = '0;
        else if (!promoted)
            starve_nxt = starve_cnt + SW'(1);

        case (state)
            ARB: begin
                if (spi_gnt && BURST_EN) begin
                    state_nxt = BURST;
                    burst_nxt = BW'(1);
                end
            end
            BURST: begin
                if (!spi_req) begin
                    state_nxt = ARB;
                    burst_nxt = '0;
                end else if (spi_gnt) begin
                    if ((burst_cnt + BW'(1)) == BW'(SPI_BURST)) begin
                        state_nxt = ARB;
                        burst_nxt = '0;
                    end else
                        burst_nxt = burst_cnt + BW'(1);
                end
            end
            default: begin
                state_nxt = ARB;
                burst_nxt = '0;
            end
        endcase
    end

    assign vid_rvalid = tag_s2[1];
    assign aud_rvalid = tag_s2[0];
    assign vid_rdata  = vid_rvalid ? mem_rdata : '0;
    assign aud_rdata  = aud_rvalid ? mem_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_frame_mem_arbiter.sv
// ============================================================================
// tb_frame_mem_arbiter: directed stimulus with a scoreboard of expected memory
// issues and read returns, checked by an independent monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_mem_arbiter;

    localparam int AW = 17;
    localparam int DW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wd;
    } iss_t;

    typedef struct packed {
        logic          aud;
        logic [DW-1:0] d;
    } rd_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rst_drv = 1'b1;
    logic          vid_req = 1'b0, aud_req = 1'b0, spi_req = 1'b0;
    logic [AW-1:0] vid_addr = '0, aud_addr = '0, spi_addr = '0;
    logic [DW-1:0] spi_wdata = '0;
    logic          vid_gnt, aud_gnt, spi_gnt, vid_rvalid, aud_rvalid;
    logic [DW-1:0] vid_rdata, aud_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] exp_mem [256];
    iss_t          iss_q [$];
    rd_t           rd_q  [$];
    int            total = 0;
    int            bad   = 0;

    frame_mem_arbiter dut (
        .CLK_40(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .aud_req(aud_req), .aud_addr(aud_addr), .aud_gnt(aud_gnt),
        .aud_rvalid(aud_rvalid), .aud_rdata(aud_rdata),
        .spi_req(spi_req), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_gnt(spi_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, write committed at the issue edge.
    always @(posedge clk) begin
        if (mem_en && mem_we)
            mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we)
            mem_rdata <= mem[mem_addr[7:0]];
    end

    // Monitor: registered outputs are compared against the scoreboard queues.
    always @(negedge clk) begin
        iss_t ei;
        rd_t  er;
        if (mem_en) begin
            total++;
            if (iss_q.size() == 0) begin
                bad++;
                $display("FAIL issue: unexpected mem_en addr=%h we=%b", mem_addr, mem_we);
            end else begin
                ei = iss_q.pop_front();
                if (mem_addr !== ei.addr || mem_we !== ei.we || (ei.we && mem_wdata !== ei.wd)) begin
                    bad++;
                    $display("FAIL issue: got addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                             mem_addr, mem_we, mem_wdata, ei.addr, ei.we, ei.wd);
                end
            end
        end else if (mem_we) begin
            total++;
            bad++;
            $display("FAIL issue: mem_we=1 without mem_en");
        end
        if (vid_rvalid || aud_rvalid) begin
            total++;
            if (vid_rvalid && aud_rvalid) begin
                bad++;
                $display("FAIL rvalid: both vid and aud asserted");
            end else if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rvalid: unexpected return vid=%b aud=%b", vid_rvalid, aud_rvalid);
            end else begin
                er = rd_q.pop_front();
                if (aud_rvalid !== er.aud || (er.aud ? aud_rdata : vid_rdata) !== er.d) begin
                    bad++;
                    $display("FAIL rdata: got aud=%b vd=%h ad=%h want aud=%b d=%h",
                             aud_rvalid, vid_rdata, aud_rdata, er.aud, er.d);
                end
            end
        end
        total++;
        if ((!vid_rvalid && vid_rdata !== '0) || (!aud_rvalid && aud_rdata !== '0)) begin
            bad++;
            $display("FAIL rdata_idle: vid_rdata=%h aud_rdata=%h", vid_rdata, aud_rdata);
        end
    end

    task automatic step(input logic v, input logic [AW-1:0] va,
                        input logic a, input logic [AW-1:0] aa,
                        input logic s, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                        input logic [2:0] want);
        iss_t ei;
        rd_t  er;
        @(negedge clk);
        reset = rst_drv;
        vid_req = v; vid_addr = va;
        aud_req = a; aud_addr = aa;
        spi_req = s; spi_addr = sa; spi_wdata = sd;
        #1;
        total++;
        if ({vid_gnt, aud_gnt, spi_gnt} !== want) begin
            bad++;
            $display("FAIL gnt: got vas=%b want vas=%b at %0t",
                     {vid_gnt, aud_gnt, spi_gnt}, want, $time);
        end
        if (want[2] || want[1]) begin
            ei.addr = want[2] ? va : aa;
            ei.we   = 1'b0;
            ei.wd   = '0;
            iss_q.push_back(ei);
            er.aud  = !want[2];
            er.d    = exp_mem[ei.addr[7:0]];
            rd_q.push_back(er);
        end else if (want[0]) begin
            ei.addr = sa;
            ei.we   = 1'b1;
            ei.wd   = sd;
            iss_q.push_back(ei);
            exp_mem[sa[7:0]] = sd;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, '0, 1'b0, '0, 1'b0, '0, '0, 3'b000);
    endtask

    task automatic chk_zero();
        total++;
        if ({vid_gnt, aud_gnt, spi_gnt, mem_en, mem_we, vid_rvalid, aud_rvalid} !== '0 ||
            mem_addr !== '0 || mem_wdata !== '0 || vid_rdata !== '0 || aud_rdata !== '0) begin
            bad++;
            $display("FAIL reset_outs: gnt=%b en=%b we=%b addr=%h wd=%h rv=%b%b vd=%h ad=%h want all 0",
                     {vid_gnt, aud_gnt, spi_gnt}, mem_en, mem_we, mem_addr, mem_wdata,
                     vid_rvalid, aud_rvalid, vid_rdata, aud_rdata);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 7 + 3);
            exp_mem[i] = 8'(i * 7 + 3);
        end
        mem[8'h10]     = 8'hA5;
        exp_mem[8'h10] = 8'hA5;

        // Reset with every requester active: no grants, all outputs zero.
        step(1'b1, 17'h10, 1'b1, 17'h11, 1'b1, 17'h12, 8'h55, 3'b000);
        step(1'b1, 17'h10, 1'b1, 17'h11, 1'b1, 17'h12, 8'h55, 3'b000);
        chk_zero();
        rst_drv = 1'b0;

        // Single video read of 0x10, expecting 0xA5 back two cycles later.
        step(1'b1, 17'h00010, 1'b0, '0, 1'b0, '0, '0, 3'b100);
        idle(3);

        // All three held: video every cycle; SPI then promoted over audio.
        for (int i = 0; i < 12; i++)
            step(1'b1, AW'(17'h20 + i), 1'b1, 17'h30, 1'b1, 17'h50, 8'hE0, 3'b100);
        step(1'b0, '0, 1'b1, 17'h30, 1'b1, 17'h50, 8'hE0, 3'b001);
        for (int k = 0; k < 3; k++)
            step(1'b0, '0, 1'b1, 17'h30, 1'b1, AW'(17'h51 + k), 8'(8'hE1 + k), 3'b001);
        step(1'b0, '0, 1'b1, 17'h30, 1'b1, 17'h54, 8'hE4, 3'b010);
        step(1'b0, '0, 1'b1, 17'h31, 1'b0, '0, '0, 3'b010);
        idle(2);

        // Audio and SPI held: 8 audio grants, 4-beat SPI burst, audio again.
        for (int i = 0; i < 8; i++)
            step(1'b0, '0, 1'b1, AW'(17'h80 + i), 1'b1, 17'h60, 8'hD0, 3'b010);
        for (int k = 0; k < 4; k++)
            step(1'b0, '0, 1'b1, 17'h88, 1'b1, AW'(17'h60 + k), 8'(8'hD0 + k), 3'b001);
        step(1'b0, '0, 1'b1, 17'h88, 1'b1, 17'h64, 8'hD4, 3'b010);
        step(1'b0, '0, 1'b1, 17'h89, 1'b0, '0, '0, 3'b010);
        idle(2);

        // Burst preempted by video on beat 2; all four beats still follow.
        for (int i = 0; i < 8; i++)
            step(1'b0, '0, 1'b1, AW'(17'h90 + i), 1'b1, 17'h70, 8'hF0, 3'b010);
        step(1'b0, '0, 1'b1, 17'h98, 1'b1, 17'h70, 8'hF0, 3'b001);
        step(1'b1, 17'h61, 1'b1, 17'h98, 1'b1, 17'h71, 8'hF1, 3'b100);
        for (int k = 1; k < 4; k++)
            step(1'b0, '0, 1'b1, 17'h98, 1'b1, AW'(17'h70 + k), 8'(8'hF0 + k), 3'b001);
        step(1'b0, '0, 1'b1, 17'h98, 1'b1, 17'h74, 8'hF4, 3'b010);
        idle(2);

        // Alternating video/audio reads, including freshly written locations.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                step(1'b1, AW'(17'h70 + i), 1'b0, '0, 1'b0, '0, '0, 3'b100);
            else
                step(1'b0, '0, 1'b1, AW'(17'h70 + i), 1'b0, '0, '0, 3'b010);
        end
        step(1'b0, '0, 1'b1, 17'h52, 1'b0, '0, '0, 3'b010);
        idle(3);

        // Audio read followed by reset: its return must be discarded.
        step(1'b0, '0, 1'b1, 17'h10, 1'b0, '0, '0, 3'b010);
        void'(rd_q.pop_back());
        rst_drv = 1'b1;
        step(1'b1, 17'h10, 1'b1, 17'h11, 1'b1, 17'h12, 8'h66, 3'b000);
        step(1'b1, 17'h10, 1'b1, 17'h11, 1'b1, 17'h12, 8'h66, 3'b000);
        chk_zero();
        rst_drv = 1'b0;
        step(1'b1, 17'h73, 1'b0, '0, 1'b0, '0, '0, 3'b100);
        idle(4);

        total++;
        if (iss_q.size() != 0 || rd_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending issues=%0d returns=%0d want 0", iss_q.size(), rd_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
